// File: rtl/efp_pkg.sv
// Shared definitions for the extended-float adder scheduler.
// Holds the packed operand layout, field widths, the scheduler FSM state
// encoding, and the mantissa-bit-count clamp helper.
package efp_pkg;

  localparam int EFP_EXP_W  = 4;
  localparam int EFP_FRAC_W = 19;
  localparam int EFP_MBIT_W = 5;
  localparam int EFP_W      = 1 + EFP_EXP_W + EFP_FRAC_W;
  localparam int EFP_CYC_W  = 19;

  typedef struct packed {
    logic                  sign;
    logic [EFP_EXP_W-1:0]  exp;
    logic [EFP_FRAC_W-1:0] frac;
  } efp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } efp_state_e;

  // Limit a requested mantissa bit count to the largest the adder supports.
  function automatic logic [EFP_MBIT_W-1:0] clamp_mbit(
    input logic [EFP_MBIT_W-1:0] m,
    input logic [EFP_MBIT_W-1:0] max_m
  );
    return (m > max_m) ? max_m : m;
  endfunction

endpackage

// File: rtl/efp_rr_arb.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req[1:0]    - request lines
//   accept      - the current grant was taken this cycle
//   gnt[1:0]    - one-hot grant (zero when no request)
//   prio        - requester currently holding priority (debug visibility)
// After reset requester 0 has priority; after an accepted grant the other
// requester gets priority.
module efp_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       prio
);

  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    if (!prio_q) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio_q <= 1'b0;
    else if (accept) prio_q <= gnt[0];
  end

  assign prio = prio_q;

endmodule

// File: rtl/efp_add_sched.sv
// Scheduler that shares one multi-cycle extended-float adder between two
// requesters.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   reqN_valid/ready, reqN_a/b,
//   reqN_mbit_a/b (N=0,1)           - operand requests
//   add_cal, add_a/b, add_mbit_a/b  - start strobe and registered operands
//   add_done, add_sign/exp/man/
//   mbits/bias                      - adder result
//   rsp_valid/ready, rsp_id, rsp_*  - response with requester id
//   rsp_cycles, rsp_err             - adder latency, timeout flag
//   state_dbg                       - current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid holds its payload until then, ready may depend on valid.
// Build option: define EFP_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT cycles); otherwise WAIT lasts until add_done and rsp_err is 0.
module efp_add_sched
  import efp_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int MAX_MBITS = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [EFP_W-1:0]      req0_a,
  input  logic [EFP_W-1:0]      req0_b,
  input  logic [EFP_MBIT_W-1:0] req0_mbit_a,
  input  logic [EFP_MBIT_W-1:0] req0_mbit_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [EFP_W-1:0]      req1_a,
  input  logic [EFP_W-1:0]      req1_b,
  input  logic [EFP_MBIT_W-1:0] req1_mbit_a,
  input  logic [EFP_MBIT_W-1:0] req1_mbit_b,
  output logic                  add_cal,
  output logic [EFP_W-1:0]      add_a,
  output logic [EFP_W-1:0]      add_b,
  output logic [EFP_MBIT_W-1:0] add_mbit_a,
  output logic [EFP_MBIT_W-1:0] add_mbit_b,
  input  logic                  add_done,
  input  logic                  add_sign,
  input  logic [EFP_EXP_W-1:0]  add_exp,
  input  logic [EFP_FRAC_W-1:0] add_man,
  input  logic [EFP_MBIT_W-1:0] add_mbits,
  input  logic [EFP_MBIT_W-1:0] add_bias,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic                  rsp_sign,
  output logic [EFP_EXP_W-1:0]  rsp_exp,
  output logic [EFP_FRAC_W-1:0] rsp_man,
  output logic [EFP_MBIT_W-1:0] rsp_mbits,
  output logic [EFP_MBIT_W-1:0] rsp_bias,
  output logic [EFP_CYC_W-1:0]  rsp_cycles,
  output logic                  rsp_err,
  output logic [1:0]            state_dbg
);

  localparam logic [EFP_MBIT_W-1:0] MBIT_MAX = EFP_MBIT_W'(MAX_MBITS);
  localparam logic [EFP_CYC_W-1:0]  TMO      = EFP_CYC_W'(TIMEOUT);
`ifdef EFP_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  efp_state_e             state_q, state_d;
  logic [1:0]             gnt;
  logic [1:0]             ready;
  logic                   accept;
  logic                   load_op, cap_rsp, timeout_hit;
  logic                   arb_prio;
  logic                   id_q;
  logic [EFP_CYC_W-1:0]   cnt_q, cnt_inc;
  logic                   err_q;

  efp_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt    (gnt),
    .prio   (arb_prio)
  );

  // rst_n gates ready so it reads 0 while reset is asserted, not just after.
  assign ready      = gnt & {2{(state_q == ST_IDLE) && rst_n}};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign accept     = |(ready & {req1_valid, req0_valid});

  // Saturating increment of the latency counter.
  assign cnt_inc = (cnt_q == {EFP_CYC_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    add_cal     = 1'b0;
    rsp_valid   = 1'b0;
    load_op     = 1'b0;
    cap_rsp     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_op = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        add_cal = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (add_done) begin
          cap_rsp = 1'b1;
          state_d = ST_RESP;
        end else if (TMO_EN && (cnt_q >= TMO)) begin
          timeout_hit = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a      <= '0;
      add_b      <= '0;
      add_mbit_a <= '0;
      add_mbit_b <= '0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      rsp_sign   <= 1'b0;
      rsp_exp    <= '0;
      rsp_man    <= '0;
      rsp_mbits  <= '0;
      rsp_bias   <= '0;
      rsp_cycles <= '0;
      err_q      <= 1'b0;
    end else begin
      if (load_op) begin
        id_q       <= gnt[1];
        add_a      <= gnt[1] ? req1_a : req0_a;
        add_b      <= gnt[1] ? req1_b : req0_b;
        add_mbit_a <= clamp_mbit(gnt[1] ? req1_mbit_a : req0_mbit_a, MBIT_MAX);
        add_mbit_b <= clamp_mbit(gnt[1] ? req1_mbit_b : req0_mbit_b, MBIT_MAX);
      end
      if (state_q == ST_ISSUE)     cnt_q <= {{(EFP_CYC_W-1){1'b0}}, 1'b1};
      else if (state_q == ST_WAIT) cnt_q <= cnt_inc;
      if (cap_rsp) begin
        rsp_sign   <= add_sign;
        rsp_exp    <= add_exp;
        rsp_man    <= add_man;
        rsp_mbits  <= add_mbits;
        rsp_bias   <= add_bias;
        rsp_cycles <= cnt_inc;
        err_q      <= 1'b0;
      end else if (timeout_hit) begin
        rsp_sign   <= 1'b0;
        rsp_exp    <= '0;
        rsp_man    <= '0;
        rsp_mbits  <= '0;
        rsp_bias   <= '0;
        rsp_cycles <= TMO;
        err_q      <= 1'b1;
      end
    end
  end

  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_efp_add_sched.sv
// Directed testbench for efp_add_sched. Inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_efp_add_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_mbit_a, req0_mbit_b, req1_mbit_a, req1_mbit_b;
  logic        add_cal;
  logic [23:0] add_a, add_b;
  logic [4:0]  add_mbit_a, add_mbit_b;
  logic        add_done, add_sign;
  logic [3:0]  add_exp;
  logic [18:0] add_man;
  logic [4:0]  add_mbits, add_bias;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_sign, rsp_err;
  logic [3:0]  rsp_exp;
  logic [18:0] rsp_man;
  logic [4:0]  rsp_mbits, rsp_bias;
  logic [18:0] rsp_cycles;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cal_count = 0;
  logic [0:0] exp_q[$];

  efp_add_sched #(.TIMEOUT(16), .MAX_MBITS(19)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mbit_a(req0_mbit_a), .req0_mbit_b(req0_mbit_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mbit_a(req1_mbit_a), .req1_mbit_b(req1_mbit_b),
    .add_cal(add_cal), .add_a(add_a), .add_b(add_b),
    .add_mbit_a(add_mbit_a), .add_mbit_b(add_mbit_b),
    .add_done(add_done), .add_sign(add_sign), .add_exp(add_exp), .add_man(add_man),
    .add_mbits(add_mbits), .add_bias(add_bias),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sign(rsp_sign), .rsp_exp(rsp_exp), .rsp_man(rsp_man),
    .rsp_mbits(rsp_mbits), .rsp_bias(rsp_bias),
    .rsp_cycles(rsp_cycles), .rsp_err(rsp_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && add_cal) cal_count++;

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0; add_done = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_mbit_a = 0; req0_mbit_b = 0; req1_mbit_a = 0; req1_mbit_b = 0;
    add_sign = 0; add_exp = 0; add_man = 0; add_mbits = 0; add_bias = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Wait (bounded) at falling edges until add_cal is seen.
  task automatic wait_cal(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (add_cal) begin ok = 1; return; end
      @(negedge clk);
    end
  endtask

  // Called at the ISSUE falling edge; raises add_done in WAIT cycle n_wait
  // and returns at the falling edge of the first RESP cycle.
  task automatic finish_add(input int n_wait, input logic s, input logic [3:0] e,
                            input logic [18:0] m, input logic [4:0] mb, input logic [4:0] bi);
    repeat (n_wait) @(negedge clk);
    add_done = 1; add_sign = s; add_exp = e; add_man = m; add_mbits = mb; add_bias = bi;
    @(negedge clk);
    add_done = 0;
  endtask

  task automatic ack();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1; req1_valid = 1; rsp_ready = 0; add_done = 0;
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready got=%b%b want=00", req1_ready, req0_ready); end
    total++; if (add_cal !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin bad++;
      $display("FAIL reset_strobes got cal=%b vld=%b err=%b want 0", add_cal, rsp_valid, rsp_err); end
    total++; if (add_a !== 24'h0 || rsp_cycles !== 19'h0 || state_dbg !== 2'd0) begin bad++;
      $display("FAIL reset_data got a=%h cyc=%h st=%0d want 0", add_a, rsp_cycles, state_dbg); end
    apply_reset();
  endtask

  task automatic test_single();
    int c0;
    bit ok;
    c0 = cal_count;
    req0_valid = 1; req0_a = 24'h380004; req0_b = 24'h380000; req0_mbit_a = 3; req0_mbit_b = 2;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL single_grant got=%b%b want=01", req1_ready, req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    total++; if (add_cal !== 1'b1 || add_a !== 24'h380004 || add_b !== 24'h380000) begin bad++;
      $display("FAIL single_issue got cal=%b a=%h b=%h want 1 380004 380000", add_cal, add_a, add_b); end
    total++; if (add_mbit_a !== 5'd3 || add_mbit_b !== 5'd2) begin bad++;
      $display("FAIL single_mbit got %0d %0d want 3 2", add_mbit_a, add_mbit_b); end
    finish_add(4, 1'b0, 4'h7, 19'h00006, 5'd3, 5'd7);
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_cycles !== 19'd5) begin bad++;
      $display("FAIL single_rsp got vld=%b id=%b cyc=%0d want 1 0 5", rsp_valid, rsp_id, rsp_cycles); end
    total++; if (rsp_sign !== 1'b0 || rsp_exp !== 4'h7 || rsp_man !== 19'h6 ||
                 rsp_mbits !== 5'd3 || rsp_bias !== 5'd7 || rsp_err !== 1'b0) begin bad++;
      $display("FAIL single_fields got s=%b e=%h m=%h mb=%0d bi=%0d err=%b want 0 7 6 3 7 0",
               rsp_sign, rsp_exp, rsp_man, rsp_mbits, rsp_bias, rsp_err); end
    total++; if (cal_count - c0 !== 1) begin bad++;
      $display("FAIL single_cal_pulses got=%0d want=1", cal_count - c0); end
    ack();
    total++; if (rsp_valid !== 1'b0 || state_dbg !== 2'd0) begin bad++;
      $display("FAIL single_idle got vld=%b st=%0d want 0 0", rsp_valid, state_dbg); end
    // add_done while idle must not produce a response.
    add_done = 1; @(negedge clk); add_done = 0; @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || state_dbg !== 2'd0) begin bad++;
      $display("FAIL stray_done got vld=%b st=%0d want 0 0", rsp_valid, state_dbg); end
    ok = 1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [0:0] e;
    apply_reset();
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    req0_valid = 1; req0_a = 24'h100000; req0_mbit_a = 4; req0_b = 24'h100001; req0_mbit_b = 4;
    req1_valid = 1; req1_a = 24'h200000; req1_mbit_a = 5; req1_b = 24'h200001; req1_mbit_b = 5;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL rr_first_grant got=%b%b want=01", req1_ready, req0_ready); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_cal(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=no_add_cal want=add_cal"); return; end
      total++; if (add_a !== (e ? 24'h200000 : 24'h100000) || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
        $display("FAIL rr_issue got a=%h rdy=%b%b want a=%h rdy=00", add_a, req1_ready, req0_ready,
                 e ? 24'h200000 : 24'h100000); end
      finish_add(1, 1'b1, 4'h2, 19'h12345, 5'd4, 5'd1);
      total++; if (rsp_valid !== 1'b1 || rsp_id !== e || rsp_cycles !== 19'd2) begin bad++;
        $display("FAIL rr_rsp got vld=%b id=%b cyc=%0d want 1 %b 2", rsp_valid, rsp_id, rsp_cycles, e); end
      ack();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    bit ok;
    req0_valid = 1; req0_a = 24'h0ABCDE; req0_mbit_a = 7; req0_b = 24'h012345; req0_mbit_b = 8;
    wait_cal(ok);
    req0_valid = 0;
    total++; if (!ok) begin bad++; $display("FAIL hold_timeout got=no_add_cal want=add_cal"); return; end
    req1_valid = 1; req1_a = 24'h300000;
    finish_add(2, 1'b1, 4'hC, 19'h5A5A5, 5'd9, 5'd3);
    for (int i = 0; i < 10; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_sign !== 1'b1 || rsp_exp !== 4'hC || rsp_man !== 19'h5A5A5 ||
                   rsp_mbits !== 5'd9 || rsp_bias !== 5'd3 || rsp_cycles !== 19'd3 || rsp_id !== 1'b0) begin bad++;
        $display("FAIL hold_stable cyc%0d got vld=%b m=%h cyc=%0d want 1 5a5a5 3", i, rsp_valid, rsp_man, rsp_cycles); end
      total++; if (req1_ready !== 1'b0 || add_cal !== 1'b0) begin bad++;
        $display("FAIL hold_nogrant cyc%0d got rdy=%b cal=%b want 0 0", i, req1_ready, add_cal); end
      @(negedge clk);
    end
    ack();
    wait_cal(ok);
    req1_valid = 0;
    total++; if (!ok || add_a !== 24'h300000) begin bad++;
      $display("FAIL hold_next got ok=%b a=%h want 1 300000", ok, add_a); end
    finish_add(1, 1'b0, 4'h0, 19'h0, 5'd0, 5'd0);
    ack();
  endtask

  task automatic test_clamp();
    bit ok;
    req0_valid = 1; req0_mbit_a = 5'd25; req0_mbit_b = 5'd19;
    wait_cal(ok);
    req0_valid = 0;
    total++; if (!ok || add_mbit_a !== 5'd19 || add_mbit_b !== 5'd19) begin bad++;
      $display("FAIL clamp got ok=%b ma=%0d mb=%0d want 1 19 19", ok, add_mbit_a, add_mbit_b); end
    finish_add(1, 1'b0, 4'h1, 19'h1, 5'd1, 5'd1);
    ack();
  endtask

  task automatic test_reset_mid();
    bit ok;
    req0_valid = 1; req0_a = 24'h0F0F0F;
    wait_cal(ok);
    req0_valid = 0;
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=no_add_cal want=add_cal"); return; end
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    total++; if (state_dbg !== 2'd0 || add_a !== 24'h0 || rsp_valid !== 1'b0) begin bad++;
      $display("FAIL rmid_async got st=%0d a=%h vld=%b want 0 0 0", state_dbg, add_a, rsp_valid); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    add_done = 1; add_man = 19'h7FFFF;
    @(negedge clk);
    add_done = 0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || state_dbg !== 2'd0) begin bad++;
      $display("FAIL rmid_late_done got vld=%b st=%0d want 0 0", rsp_valid, state_dbg); end
    req0_valid = 1; req1_valid = 1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL rmid_ptr got=%b%b want=01", req1_ready, req0_ready); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    finish_add(1, 1'b0, 4'h0, 19'h0, 5'd0, 5'd0);
    ack();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    req0_valid = 1;
    wait_cal(ok);
    req0_valid = 0;
    total++; if (!ok) begin bad++; $display("FAIL tmo_start got=no_add_cal want=add_cal"); return; end
`ifdef EFP_SCHED_TIMEOUT_EN
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    total++; if (n !== 17 || rsp_err !== 1'b1 || rsp_cycles !== 19'd16 || rsp_man !== 19'h0 || rsp_exp !== 4'h0) begin bad++;
      $display("FAIL tmo_rsp got n=%0d err=%b cyc=%0d man=%h want 17 1 16 0", n, rsp_err, rsp_cycles, rsp_man); end
    ack();
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) n++;
    end
    total++; if (n !== 0) begin bad++;
      $display("FAIL tmo_none got early_rsp_cycles=%0d want 0", n); end
    finish_add(0, 1'b0, 4'h3, 19'h3, 5'd3, 5'd3);
    total++; if (rsp_valid !== 1'b1 || rsp_cycles !== 19'd41 || rsp_err !== 1'b0) begin bad++;
      $display("FAIL tmo_late_done got vld=%b cyc=%0d err=%b want 1 41 0", rsp_valid, rsp_cycles, rsp_err); end
    ack();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_clamp();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
